// File: rtl/sd_cmd_phy.sv
// SD CMD-line PHY: serialises a 48-bit command frame with generated CRC7 and
// deserialises the card's short or long response, flagging timeout/CRC/end/index faults.
module sd_cmd_phy #(
  parameter int ARG_WIDTH        = 32,
  parameter int TIMEOUT_CYCLES   = 64,
  parameter int LONG_RESP_WIDTH  = 136,
  parameter int SHORT_RESP_WIDTH = 48
) (
  input  logic                       clk_SD,
  input  logic                       reset_host,
  input  logic                       start,
  input  logic [5:0]                 cmd_index,
  input  logic [ARG_WIDTH-1:0]       cmd_argument,
  input  logic [1:0]                 resp_type,
  output logic                       CMD_PIN_OUT,
  output logic                       cmd_pin_oe,
  input  logic                       CMD_PIN_IN,
  output logic                       busy,
  output logic                       done,
  output logic [LONG_RESP_WIDTH-1:0] response,
  output logic                       timeout,
  output logic                       crc_error,
  output logic                       end_bit_error,
  output logic                       index_error
);

  localparam int FRAME_LEN = ARG_WIDTH + 16;
  localparam int DATA_LEN  = ARG_WIDTH + 8;
  localparam int TXW       = $clog2(FRAME_LEN);
  localparam int RXW       = $clog2(LONG_RESP_WIDTH + 1);
  localparam int TOW       = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [TXW-1:0] TX_DATA_END = TXW'(DATA_LEN - 1);
  localparam logic [TXW-1:0] TX_CRC_END  = TXW'(FRAME_LEN - 2);
  localparam logic [TXW-1:0] TX_LAST     = TXW'(FRAME_LEN - 1);
  localparam logic [TOW-1:0] TO_LAST     = TOW'(TIMEOUT_CYCLES - 1);
  localparam logic [RXW-1:0] RX_HDR      = RXW'(8);
  localparam logic [RXW-1:0] LONG_CRC_END  = RXW'(LONG_RESP_WIDTH - 8);
  localparam logic [RXW-1:0] SHORT_CRC_END = RXW'(SHORT_RESP_WIDTH - 8);
  localparam logic [RXW-1:0] LONG_LAST   = RXW'(LONG_RESP_WIDTH - 1);
  localparam logic [RXW-1:0] SHORT_LAST  = RXW'(SHORT_RESP_WIDTH - 1);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_SEND       = 3'd1;
  localparam logic [2:0] S_WAIT_START = 3'd2;
  localparam logic [2:0] S_RECEIVE    = 3'd3;
  localparam logic [2:0] S_DONE       = 3'd4;

  logic [2:0]                 state_q, state_d;
  logic [DATA_LEN-2:0]        tx_sr_q, tx_sr_d;
  logic [TXW-1:0]             tx_cnt_q, tx_cnt_d;
  logic [6:0]                 crc_q, crc_d;
  logic                       pin_q, pin_d;
  logic                       oe_q, oe_d;
  logic [5:0]                 idx_q, idx_d;
  logic [1:0]                 rtype_q, rtype_d;
  logic [TOW-1:0]             wait_cnt_q, wait_cnt_d;
  logic [RXW-1:0]             rx_cnt_q, rx_cnt_d;
  logic [LONG_RESP_WIDTH-1:0] resp_q, resp_d;
  logic                       timeout_q, timeout_d;
  logic                       crc_err_q, crc_err_d;
  logic                       end_err_q, end_err_d;
  logic                       idx_err_q, idx_err_d;

  logic                       long_resp;
  logic [RXW-1:0]             rx_last;
  logic                       crc_take;

  // Serial CRC7 (x^7 + x^3 + 1): feedback taps land on bits 3 and 0.
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction

  assign long_resp = (rtype_q == 2'b10);
  assign rx_last   = long_resp ? LONG_LAST : SHORT_LAST;
  // rx_cnt_q is the position (from the start bit) of the bit arriving this cycle.
  assign crc_take  = long_resp ? ((rx_cnt_q >= RX_HDR) && (rx_cnt_q < LONG_CRC_END))
                               : (rx_cnt_q < SHORT_CRC_END);

  always_comb begin
    state_d    = state_q;
    tx_sr_d    = tx_sr_q;
    tx_cnt_d   = tx_cnt_q;
    crc_d      = crc_q;
    pin_d      = pin_q;
    oe_d       = oe_q;
    idx_d      = idx_q;
    rtype_d    = rtype_q;
    wait_cnt_d = wait_cnt_q;
    rx_cnt_d   = rx_cnt_q;
    resp_d     = resp_q;
    timeout_d  = timeout_q;
    crc_err_d  = crc_err_q;
    end_err_d  = end_err_q;
    idx_err_d  = idx_err_q;

    case (state_q)
      S_IDLE: begin
        pin_d = 1'b1;
        oe_d  = 1'b0;
        if (start) begin
          idx_d      = cmd_index;
          rtype_d    = resp_type;
          tx_sr_d    = {1'b1, cmd_index, cmd_argument};
          tx_cnt_d   = '0;
          crc_d      = crc7_step(7'd0, 1'b0);
          pin_d      = 1'b0;
          oe_d       = 1'b1;
          wait_cnt_d = '0;
          rx_cnt_d   = '0;
          resp_d     = '0;
          timeout_d  = 1'b0;
          crc_err_d  = 1'b0;
          end_err_d  = 1'b0;
          idx_err_d  = 1'b0;
          state_d    = S_SEND;
        end
      end

      S_SEND: begin
        tx_cnt_d = tx_cnt_q + 1'b1;
        if (tx_cnt_q == TX_LAST) begin
          pin_d      = 1'b1;
          oe_d       = 1'b0;
          tx_cnt_d   = '0;
          crc_d      = 7'd0;
          wait_cnt_d = '0;
          state_d    = (rtype_q == 2'b00) ? S_DONE : S_WAIT_START;
        end else if (tx_cnt_q < TX_DATA_END) begin
          pin_d   = tx_sr_q[DATA_LEN-2];
          tx_sr_d = {tx_sr_q[DATA_LEN-3:0], 1'b0};
          crc_d   = crc7_step(crc_q, tx_sr_q[DATA_LEN-2]);
        end else if (tx_cnt_q < TX_CRC_END) begin
          pin_d = crc_q[6];
          crc_d = {crc_q[5:0], 1'b0};
        end else begin
          pin_d = 1'b1;
        end
      end

      S_WAIT_START: begin
        // A start bit in the final window cycle takes priority over the timeout.
        if (!CMD_PIN_IN) begin
          resp_d   = {resp_q[LONG_RESP_WIDTH-2:0], 1'b0};
          rx_cnt_d = RXW'(1);
          if (crc_take) crc_d = crc7_step(crc_q, 1'b0);
          state_d  = S_RECEIVE;
        end else if (wait_cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      S_RECEIVE: begin
        resp_d   = {resp_q[LONG_RESP_WIDTH-2:0], CMD_PIN_IN};
        rx_cnt_d = rx_cnt_q + 1'b1;
        if (crc_take) crc_d = crc7_step(crc_q, CMD_PIN_IN);
        if (rx_cnt_q == rx_last) begin
          crc_err_d = (crc_q != resp_d[7:1]);
          end_err_d = ~CMD_PIN_IN;
          idx_err_d = ~long_resp && (resp_d[SHORT_RESP_WIDTH-3 -: 6] != idx_q);
          state_d   = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_SD or posedge reset_host) begin
    if (reset_host) begin
      state_q    <= S_IDLE;
      tx_sr_q    <= '0;
      tx_cnt_q   <= '0;
      crc_q      <= '0;
      pin_q      <= 1'b1;
      oe_q       <= 1'b0;
      idx_q      <= '0;
      rtype_q    <= '0;
      wait_cnt_q <= '0;
      rx_cnt_q   <= '0;
      resp_q     <= '0;
      timeout_q  <= 1'b0;
      crc_err_q  <= 1'b0;
      end_err_q  <= 1'b0;
      idx_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_sr_q    <= tx_sr_d;
      tx_cnt_q   <= tx_cnt_d;
      crc_q      <= crc_d;
      pin_q      <= pin_d;
      oe_q       <= oe_d;
      idx_q      <= idx_d;
      rtype_q    <= rtype_d;
      wait_cnt_q <= wait_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      resp_q     <= resp_d;
      timeout_q  <= timeout_d;
      crc_err_q  <= crc_err_d;
      end_err_q  <= end_err_d;
      idx_err_q  <= idx_err_d;
    end
  end

  assign CMD_PIN_OUT   = pin_q;
  assign cmd_pin_oe    = oe_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign response      = resp_q;
  assign timeout       = timeout_q;
  assign crc_error     = crc_err_q;
  assign end_bit_error = end_err_q;
  assign index_error   = idx_err_q;

endmodule
